// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding read to a handshaked instruction memory,
// a single-entry decode slot with a skid buffer, redirect squashing and HALT stop.
module fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_rd,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        imem_done,
  input  logic        decode_stall,
  input  logic        redirect_en,
  input  logic [15:0] redirect_pc,
  output logic [15:0] instr_out,
  output logic [15:0] pc_plus2_out,
  output logic        instr_valid,
  output logic        halted
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ISSUE = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] HALT  = 3'd4;

  logic [2:0]  stateReg;
  logic [15:0] pcReg;
  logic [15:0] instrReg;
  logic [15:0] pcPlus2Reg;
  logic        validReg;
  logic [15:0] skidReg;
  logic        skidValidReg;
  logic        squashReg;
  logic        haltedReg;

  logic [15:0] pcNext;
  logic        slotFree;
  logic        memIsHalt;
  logic        skidIsHalt;

  assign pcNext     = pcReg + 16'd2;
  assign slotFree   = ~validReg | ~decode_stall;
  assign memIsHalt  = (imem_data[15:11] == 5'b00000);
  assign skidIsHalt = (skidReg[15:11] == 5'b00000);

  assign imem_rd      = (stateReg == ISSUE) & ~rst;
  assign imem_addr    = pcReg;
  assign instr_out    = instrReg;
  assign pc_plus2_out = pcPlus2Reg;
  assign instr_valid  = validReg;
  assign halted       = haltedReg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg     <= IDLE;
      pcReg        <= RESET_PC;
      instrReg     <= NOP_INSTR;
      pcPlus2Reg   <= 16'h0000;
      validReg     <= 1'b0;
      skidReg      <= 16'h0000;
      skidValidReg <= 1'b0;
      squashReg    <= 1'b0;
      haltedReg    <= 1'b0;
    end else if (redirect_en) begin
      pcReg        <= redirect_pc;
      validReg     <= 1'b0;
      instrReg     <= NOP_INSTR;
      skidValidReg <= 1'b0;
      haltedReg    <= 1'b0;
      case (stateReg)
        ISSUE: begin
          // The read launched this cycle targets the old path; drop its data.
          stateReg  <= WAIT;
          squashReg <= 1'b1;
        end
        WAIT: begin
          if (imem_done) begin
            stateReg  <= ISSUE;
            squashReg <= 1'b0;
          end else begin
            squashReg <= 1'b1;
          end
        end
        default: begin
          stateReg  <= ISSUE;
          squashReg <= 1'b0;
        end
      endcase
    end else begin
      // Accepted slot empties unless a load below overwrites it at the same edge.
      if (validReg && !decode_stall) begin
        validReg <= 1'b0;
        instrReg <= NOP_INSTR;
      end
      case (stateReg)
        IDLE:  stateReg <= ISSUE;
        ISSUE: stateReg <= WAIT;
        WAIT: begin
          if (imem_done) begin
            if (squashReg) begin
              squashReg <= 1'b0;
              stateReg  <= ISSUE;
            end else if (slotFree) begin
              instrReg   <= imem_data;
              pcPlus2Reg <= pcNext;
              validReg   <= 1'b1;
              pcReg      <= pcNext;
              haltedReg  <= memIsHalt;
              stateReg   <= memIsHalt ? HALT : ISSUE;
            end else begin
              skidReg      <= imem_data;
              skidValidReg <= 1'b1;
              stateReg     <= HOLD;
            end
          end
        end
        HOLD: begin
          if (!decode_stall && skidValidReg) begin
            instrReg     <= skidReg;
            pcPlus2Reg   <= pcNext;
            validReg     <= 1'b1;
            pcReg        <= pcNext;
            skidValidReg <= 1'b0;
            haltedReg    <= skidIsHalt;
            stateReg     <= skidIsHalt ? HALT : ISSUE;
          end
        end
        HALT:    stateReg <= HALT;
        default: stateReg <= IDLE;
      endcase
    end
  end

endmodule
